// File: rtl/rv32_mem_pkg.sv
// Shared types for the rv32i unified-memory port arbiter: owner tags and the
// memory request field bundle.
package rv32_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [3:0]        be;
    } mem_req_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order owner-tag FIFO for the memory port arbiter. One tag is pushed per
// accepted memory request and popped per memory response.
module arb_tag_fifo
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  owner_e                   push_tag,
    input  logic                     pop,
    output owner_e                   pop_tag,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] tags_q, tags_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_tag = owner_e'(tags_q[rd_ptr_q]);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            tags_d[wr_ptr_q] = push_tag;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            tags_q   <= tags_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and DM with DM fixed priority and
// in-order response routing. MEM_ARB_STARVE_GUARD_EN adds the IF starvation guard.
module mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [WORD_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    input  logic [3:0]        dm_be,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [WORD_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              rsp_err
);

    localparam int CW = $clog2(MAX_OUTST) + 1;

    if (MAX_OUTST < 2 || (MAX_OUTST & (MAX_OUTST - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: MAX_OUTST must be a power of two >= 2 and STARVE_MAX >= 1");
    end

    logic          full, empty;
    logic [CW-1:0] count;
    owner_e        head_tag;
    logic          force_if, sel_dm, accept, pop;
    logic          rsp_err_q, rsp_err_d;
    mem_req_t      req_sel;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign force_if = if_req & (starve_q == SW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (dm_gnt && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign sel_dm = dm_req & ~force_if;

    // Full is judged on the registered count only, so a same-cycle response
    // never opens a slot combinationally.
    assign mem_req = (if_req | dm_req) & ~full & ~reset;
    assign accept  = mem_req & mem_gnt;
    assign dm_gnt  = accept & sel_dm;
    assign if_gnt  = accept & ~sel_dm;

    assign if_stall = if_req & ~if_gnt & ~reset;

    always_comb begin
        req_sel = '0;
        if (!reset) begin
            if (sel_dm) begin
                req_sel.we    = dm_we;
                req_sel.addr  = dm_addr;
                req_sel.wdata = dm_wdata;
                req_sel.be    = dm_be;
            end else begin
                req_sel.we    = 1'b0;
                req_sel.addr  = if_addr;
                req_sel.wdata = '0;
                req_sel.be    = 4'hF;
            end
        end
    end

    assign mem_we    = req_sel.we;
    assign mem_addr  = req_sel.addr;
    assign mem_wdata = req_sel.wdata;
    assign mem_be    = req_sel.be;

    assign pop       = mem_rvalid & ~empty & ~reset;
    assign if_rvalid = pop & (head_tag == OWN_IF);
    assign dm_rvalid = pop & (head_tag == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

    // A response with nothing outstanding (e.g. one in flight across a reset)
    // is dropped and flagged until the next reset.
    assign rsp_err_d = rsp_err_q | (mem_rvalid & (count == '0));
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_tag (sel_dm ? OWN_DM : OWN_IF),
        .pop      (pop),
        .pop_tag  (head_tag),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency in-order memory model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_stall, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_OUTST  (4),
        .STARVE_MAX (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_stall   (if_stall),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_be      (dm_be),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_err    (rsp_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t rsp_q[$];
    int   cyc = 0;
    bit   hold_rsp = 1'b0;

    logic        s_if_gnt, s_if_stall, s_if_rvalid, s_dm_gnt, s_dm_rvalid;
    logic        s_mem_req, s_mem_we, s_rsp_err;
    logic [31:0] s_if_rdata, s_dm_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_be;

    // Snapshot the cycle at the falling edge, then let the memory model accept
    // and schedule responses after the rising edge.
    task automatic do_cycle();
        rsp_t r;
        @(negedge clk);
        s_if_gnt    = if_gnt;
        s_if_stall  = if_stall;
        s_if_rvalid = if_rvalid;
        s_if_rdata  = if_rdata;
        s_dm_gnt    = dm_gnt;
        s_dm_rvalid = dm_rvalid;
        s_dm_rdata  = dm_rdata;
        s_mem_req   = mem_req;
        s_mem_we    = mem_we;
        s_mem_addr  = mem_addr;
        s_mem_wdata = mem_wdata;
        s_mem_be    = mem_be;
        s_rsp_err   = rsp_err;
        if (mem_req && mem_gnt) begin
            r.data = mem_word(mem_addr);
            r.due  = cyc + LAT;
            rsp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!hold_rsp && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    logic [7:0] exp_dm;
    int         n_rv;

    initial begin
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h4;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8; dm_wdata = 32'h1234_5678; dm_be = 4'hF;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;

        // reset: everything quiet despite active inputs
        do_cycle();
        check("rst_mem_req", 32'(s_mem_req), 32'd0);
        check("rst_gnt", {30'd0, s_if_gnt, s_dm_gnt}, 32'd0);
        check("rst_if_stall", 32'(s_if_stall), 32'd0);
        check("rst_rvalid", {30'd0, s_if_rvalid, s_dm_rvalid}, 32'd0);
        check("rst_mem_fields", s_mem_addr | s_mem_wdata | {28'd0, s_mem_be} | 32'(s_mem_we), 32'd0);
        check("rst_rdata", s_if_rdata | s_dm_rdata, 32'd0);
        check("rst_rsp_err", 32'(s_rsp_err), 32'd0);
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        do_cycle();
        check("idle_mem_req", 32'(s_mem_req), 32'd0);
        check("idle_rsp_err", 32'(s_rsp_err), 32'd0);

        // IF only, latency 2
        if_req = 1'b1; if_addr = 32'h0;
        do_cycle();
        check("if1_gnt0", 32'(s_if_gnt), 32'd1);
        check("if1_addr0", s_mem_addr, 32'h0);
        check("if1_be", 32'(s_mem_be), 32'hF);
        check("if1_we", 32'(s_mem_we), 32'd0);
        if_addr = 32'h4;
        do_cycle();
        check("if1_gnt1", 32'(s_if_gnt), 32'd1);
        check("if1_rv_early", 32'(s_if_rvalid), 32'd0);
        if_addr = 32'h8;
        do_cycle();
        check("if1_gnt2", 32'(s_if_gnt), 32'd1);
        check("if1_rv0", 32'(s_if_rvalid), 32'd1);
        check("if1_rdata0", s_if_rdata, 32'h5A5A_C3C3);
        check("if1_dm_rv0", 32'(s_dm_rvalid), 32'd0);
        if_req = 1'b0;
        do_cycle();
        check("if1_rdata1", s_if_rdata, 32'h5A5A_C3C7);
        check("if1_dm_rv1", 32'(s_dm_rvalid), 32'd0);
        do_cycle();
        check("if1_rdata2", s_if_rdata, 32'h5A5A_C3CB);
        check("if1_dm_rdata2", s_dm_rdata, 32'd0);
        do_cycle();
        check("if1_rv_done", 32'(s_if_rvalid), 32'd0);

        // simultaneous IF and DM load
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_be = 4'hF;
        do_cycle();
        check("sim_dm_gnt", 32'(s_dm_gnt), 32'd1);
        check("sim_if_gnt", 32'(s_if_gnt), 32'd0);
        check("sim_if_stall", 32'(s_if_stall), 32'd1);
        check("sim_addr_dm", s_mem_addr, 32'h100);
        dm_req = 1'b0;
        do_cycle();
        check("sim_if_gnt2", 32'(s_if_gnt), 32'd1);
        check("sim_addr_if", s_mem_addr, 32'h10);
        check("sim_if_stall2", 32'(s_if_stall), 32'd0);
        if_req = 1'b0;
        do_cycle();
        check("sim_dm_rv", 32'(s_dm_rvalid), 32'd1);
        check("sim_dm_rdata", s_dm_rdata, 32'h5A5A_C2C3);
        check("sim_if_rv_first", 32'(s_if_rvalid), 32'd0);
        check("sim_if_rdata_zero", s_if_rdata, 32'd0);
        do_cycle();
        check("sim_if_rv", 32'(s_if_rvalid), 32'd1);
        check("sim_if_rdata", s_if_rdata, 32'h5A5A_C3D3);
        check("sim_dm_rv_second", 32'(s_dm_rvalid), 32'd0);
        do_cycle();

        // full FIFO: four grants, then blocked until one cycle after first response
        hold_rsp = 1'b1;
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_addr = 32'h20 + 32'(4 * i);
            do_cycle();
            check($sformatf("full_gnt%0d", i), 32'(s_if_gnt), 32'd1);
        end
        if_addr = 32'h30;
        do_cycle();
        check("full_blocked_req", 32'(s_mem_req), 32'd0);
        check("full_blocked_stall", 32'(s_if_stall), 32'd1);
        hold_rsp = 1'b0;
        do_cycle();
        check("full_still_blocked", 32'(s_mem_req), 32'd0);
        do_cycle();
        check("full_rv_first", 32'(s_if_rvalid), 32'd1);
        check("full_rdata_first", s_if_rdata, 32'h5A5A_C3E3);
        check("full_no_same_cycle_req", 32'(s_mem_req), 32'd0);
        check("full_no_same_cycle_gnt", 32'(s_if_gnt), 32'd0);
        do_cycle();
        check("full_5th_gnt", 32'(s_if_gnt), 32'd1);
        check("full_5th_addr", s_mem_addr, 32'h30);
        check("full_rdata_2nd", s_if_rdata, 32'h5A5A_C3E7);
        if_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            check($sformatf("full_drain%0d", i), s_if_rdata, mem_word(32'h28 + 32'(4 * i)));
        end
        do_cycle();

        // store with partial byte enables
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        do_cycle();
        check("st_gnt", 32'(s_dm_gnt), 32'd1);
        check("st_we", 32'(s_mem_we), 32'd1);
        check("st_be", 32'(s_mem_be), 32'h3);
        check("st_wdata", s_mem_wdata, 32'hDEAD_BEEF);
        check("st_addr", s_mem_addr, 32'h200);
        dm_req = 1'b0; dm_we = 1'b0;
        do_cycle();
        check("st_rv_early", 32'(s_dm_rvalid), 32'd0);
        do_cycle();
        check("st_ack", 32'(s_dm_rvalid), 32'd1);
        check("st_if_rv", 32'(s_if_rvalid), 32'd0);
        do_cycle();
        check("st_ack_single", 32'(s_dm_rvalid), 32'd0);

        // reset with three requests in flight
        hold_rsp = 1'b1;
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'h40 + 32'(4 * i);
            do_cycle();
        end
        check("mid_gnt3", 32'(s_if_gnt), 32'd1);
        reset = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        do_cycle();
        check("mid_rst_req", 32'(s_mem_req), 32'd0);
        check("mid_rst_gnt", {30'd0, s_if_gnt, s_dm_gnt}, 32'd0);
        check("mid_rst_stall", 32'(s_if_stall), 32'd0);
        check("mid_rst_addr", s_mem_addr, 32'd0);
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; hold_rsp = 1'b0;
        do_cycle();
        check("mid_rv_a", {30'd0, s_if_rvalid, s_dm_rvalid}, 32'd0);
        check("mid_err_a", 32'(s_rsp_err), 32'd0);
        do_cycle();
        check("mid_rv_b", {30'd0, s_if_rvalid, s_dm_rvalid}, 32'd0);
        check("mid_err_b", 32'(s_rsp_err), 32'd0);
        do_cycle();
        check("mid_rv_c", {30'd0, s_if_rvalid, s_dm_rvalid}, 32'd0);
        check("mid_err_c", 32'(s_rsp_err), 32'd1);
        do_cycle();
        check("mid_rv_d", {30'd0, s_if_rvalid, s_dm_rvalid}, 32'd0);
        check("mid_err_d", 32'(s_rsp_err), 32'd1);
        do_cycle();

        // both requesters held high
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_dm = 8'b0111_0111;
`else
        exp_dm = 8'b1111_1111;
`endif
        if_req = 1'b1; if_addr = 32'h50;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hF;
        for (int i = 0; i < 8; i++) begin
            do_cycle();
            check($sformatf("starve_dm_gnt%0d", i), 32'(s_dm_gnt), 32'(exp_dm[i]));
            check($sformatf("starve_if_gnt%0d", i), 32'(s_if_gnt), 32'(!exp_dm[i]));
        end
        if_req = 1'b0; dm_req = 1'b0;
        n_rv = 0;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            n_rv += int'(s_if_rvalid) + int'(s_dm_rvalid);
        end
        check("starve_drain_rv", 32'(n_rv), 32'd2);
        check("err_sticky", 32'(s_rsp_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
